// File: rtl/grad_weight_div.sv
// Gradient-weight divider: scaled_hs = floor(hs*(2^Q-1)/(hs+vs)), scaled_vs = (2^Q-1)-scaled_hs.
// Serial radix-2 restoring division, one quotient bit per clock.
module grad_weight_div #(
  parameter int unsigned W = 16,
  parameter int unsigned Q = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] grad_hs,
  input  logic [W-1:0] grad_vs,
  output logic [Q-1:0] scaled_hs,
  output logic [Q-1:0] scaled_vs,
  output logic         valid,
  output logic         ready
);

  localparam int unsigned CW = $clog2(Q);
  localparam int unsigned RW = W + 1;
  localparam logic [Q-1:0] QMax   = {Q{1'b1}};
  localparam logic [Q-1:0] HsZero = {1'b0, {(Q-1){1'b1}}};
  localparam logic [Q-1:0] VsZero = {1'b1, {(Q-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StLoad, StDiv, StDone} state_e;

  state_e         state_q;
  logic [W-1:0]   hs_q, vs_q;
  logic [W:0]     div_q, rem_q;
  logic [Q-1:0]   low_q, quo_q;
  logic [CW-1:0]  cnt_q;

  logic [W+Q-1:0] dividend;
  logic [W:0]     sum;
  logic [W+1:0]   trial;
  logic           ge;
  logic [W:0]     rem_next;
  logic [Q-1:0]   quo_next;

  assign sum      = {1'b0, hs_q} + {1'b0, vs_q};
  assign dividend = {hs_q, {Q{1'b0}}} - {{Q{1'b0}}, hs_q};

  // The quotient is known to fit in Q bits, so the upper W dividend bits seed the remainder.
  assign trial    = {rem_q, low_q[Q-1]};
  assign ge       = trial >= {1'b0, div_q};
  assign rem_next = RW'(ge ? trial - {1'b0, div_q} : trial);
  assign quo_next = {quo_q[Q-2:0], ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      hs_q      <= '0;
      vs_q      <= '0;
      div_q     <= '0;
      rem_q     <= '0;
      low_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      scaled_hs <= '0;
      scaled_vs <= '0;
      valid     <= 1'b0;
      ready     <= 1'b1;
    end else begin
      valid <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            hs_q    <= grad_hs;
            vs_q    <= grad_vs;
            ready   <= 1'b0;
            state_q <= StLoad;
          end else begin
            state_q <= StIdle;
          end
        end
        StLoad: begin
          div_q   <= sum;
          rem_q   <= {1'b0, dividend[W+Q-1:Q]};
          low_q   <= dividend[Q-1:0];
          quo_q   <= '0;
          cnt_q   <= '0;
          state_q <= StDiv;
        end
        StDiv: begin
          rem_q <= rem_next;
          low_q <= {low_q[Q-2:0], 1'b0};
          quo_q <= quo_next;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(Q - 1)) begin
            // Zero divisor runs the full division anyway so latency stays fixed.
            if (div_q == '0) begin
              scaled_hs <= HsZero;
              scaled_vs <= VsZero;
            end else begin
              scaled_hs <= quo_next;
              scaled_vs <= QMax - quo_next;
            end
            valid   <= 1'b1;
            ready   <= 1'b1;
            state_q <= StDone;
          end
        end
        default: begin
          ready   <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
